// File: rtl/mem_arbiter.sv
// Shares one 64-bit memory port between the fetch (read-only) and data
// (read/write) requesters of the sequential Y86-64 core; all outputs registered.
module mem_arbiter #(
  parameter int unsigned MEM_SIZE = 2048,
  parameter int unsigned AW       = 64,
  parameter int unsigned DW       = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic          f_err,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_e;
  typedef enum logic {OWN_F, OWN_D} owner_e;

  // Highest byte address at which a full 8-byte access still fits.
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 8);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  logic            m_en_q, m_en_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic            f_valid_q, f_valid_d, d_valid_q, d_valid_d;
  logic            f_err_q, f_err_d, d_err_q, d_err_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

  logic            pick_f;
  logic [AW-1:0]   sel_addr;
  logic            sel_ok;
  logic [DW-1:0]   resp_data;

  // Ties go to whoever did not win last, so F and D alternate under contention.
  assign pick_f    = f_req && (!d_req || last_q == OWN_D);
  assign sel_addr  = pick_f ? f_addr : d_addr;
  assign sel_ok    = (sel_addr <= LAST_ADDR);
  assign resp_data = m_we_q ? '0 : m_rdata;

  // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    f_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    f_valid_d = 1'b0;
    d_valid_d = 1'b0;
    f_err_d   = 1'b0;
    d_err_d   = 1'b0;
    f_rdata_d = '0;
    d_rdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          owner_d   = pick_f ? OWN_F : OWN_D;
          last_d    = pick_f ? OWN_F : OWN_D;
          f_gnt_d   = pick_f;
          d_gnt_d   = !pick_f;
          m_addr_d  = sel_addr;
          m_wdata_d = pick_f ? '0 : d_wdata;
          if (sel_ok) begin
            state_d = S_BUSY;
            m_en_d  = 1'b1;
            m_we_d  = !pick_f && d_we;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_BUSY: begin
        if (m_ack) begin
          state_d = S_IDLE;
          if (owner_q == OWN_F) begin
            f_valid_d = 1'b1;
            f_rdata_d = resp_data;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = resp_data;
          end
        end else begin
          m_en_d = 1'b1;
          m_we_d = m_we_q;
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
        if (owner_q == OWN_F) begin
          f_valid_d = 1'b1;
          f_err_d   = 1'b1;
        end else begin
          d_valid_d = 1'b1;
          d_err_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_F;
      last_q    <= OWN_D;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      f_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      f_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      f_gnt_q   <= f_gnt_d;
      d_gnt_q   <= d_gnt_d;
      f_valid_q <= f_valid_d;
      d_valid_q <= d_valid_d;
      f_err_q   <= f_err_d;
      d_err_q   <= d_err_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign f_gnt   = f_gnt_q;
  assign f_valid = f_valid_q;
  assign f_err   = f_err_q;
  assign f_rdata = f_rdata_q;
  assign d_gnt   = d_gnt_q;
  assign d_valid = d_valid_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_gnt, f_valid, f_err;
  logic [63:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_gnt, d_valid, d_err;
  logic [63:0] d_rdata;
  logic        m_en, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [63:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Memory seen through the DUT's port, and the bench's own expectation of it.
  logic [63:0] phys    [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  bit          auto_mem = 1'b1;
  int          ack_delay = 0;
  int          busy_cnt = 0;

  typedef struct {
    bit          f_gnt, d_gnt, m_en, m_we;
    logic [63:0] m_addr, m_wdata;
    int          lat;
    bit          vf, vd, err, stable, clean;
    logic [63:0] rdata;
  } obs_t;

  typedef struct {
    bit          f_req;
    logic [63:0] f_addr;
    bit          d_req, d_we;
    logic [63:0] d_addr, d_wdata;
    int          delay;
    bit          exp_f, exp_ok;
    logic [63:0] exp_rdata;
  } vec_t;

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic preload(input logic [63:0] a, input logic [63:0] v);
    phys[a]    = v;
    ref_mem[a] = v;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs are looked at 1 ns after the edge, then the memory responds.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (m_en) begin
        if (busy_cnt == ack_delay) begin
          m_ack   = 1'b1;
          m_rdata = phys.exists(m_addr) ? phys[m_addr] : init_val(m_addr);
          if (m_we) phys[m_addr] = m_wdata;
        end else begin
          m_ack = 1'b0;
        end
        busy_cnt++;
      end else begin
        m_ack    = 1'b0;
        busy_cnt = 0;
      end
    end
  endtask

  task automatic apply_reset();
    f_req = 1'b0;
    d_req = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Runs one transaction from the grant cycle to the valid cycle and records what was seen.
  task automatic do_txn(input int delay, input int raise_d, output obs_t o);
    bit done;
    ack_delay = delay;
    tick();
    o.f_gnt = f_gnt;   o.d_gnt = d_gnt;   o.m_en = m_en;   o.m_we = m_we;
    o.m_addr = m_addr; o.m_wdata = m_wdata;
    o.lat = 0; o.vf = 1'b0; o.vd = 1'b0; o.err = 1'b0; o.rdata = '0;
    o.stable = 1'b1; o.clean = 1'b1;
    if (f_gnt) f_req = 1'b0;
    if (d_gnt) d_req = 1'b0;
    done = 1'b0;
    for (int c = 2; c <= 60 && !done; c++) begin
      if (c == raise_d) d_req = 1'b1;
      tick();
      if (f_valid || d_valid) begin
        done    = 1'b1;
        o.lat   = c;
        o.vf    = f_valid;
        o.vd    = d_valid;
        o.err   = f_valid ? f_err : d_err;
        o.rdata = f_valid ? f_rdata : d_rdata;
        if (f_gnt || d_gnt || m_en) o.clean = 1'b0;
      end else if (f_gnt || d_gnt || m_en !== o.m_en || m_addr !== o.m_addr ||
                   m_we !== o.m_we || m_wdata !== o.m_wdata) begin
        o.stable = 1'b0;
      end
    end
  endtask

  task automatic check_txn(input string tag, input obs_t o, input bit exp_f, input bit ok,
                           input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                           input int delay, input logic [63:0] rdata);
    check({tag, " gnt{f,d}"}, 64'({o.f_gnt, o.d_gnt}), 64'({exp_f, !exp_f}));
    check({tag, " m_en"}, 64'(o.m_en), 64'(ok));
    if (ok) begin
      check({tag, " m_addr"}, o.m_addr, addr);
      check({tag, " m_we"}, 64'(o.m_we), 64'(we));
      if (we) check({tag, " m_wdata"}, o.m_wdata, wdata);
    end
    check({tag, " latency"}, 64'(o.lat), 64'(ok ? delay + 2 : 2));
    check({tag, " valid{f,d}"}, 64'({o.vf, o.vd}), 64'({exp_f, !exp_f}));
    check({tag, " err"}, 64'(o.err), 64'(!ok));
    check({tag, " rdata"}, o.rdata, rdata);
    check({tag, " hold stable"}, 64'(o.stable), 64'd1);
    check({tag, " no gnt/m_en with valid"}, 64'(o.clean), 64'd1);
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 64'($urandom_range(0, 15)) << 3;
    else if (r == 7) return 64'($urandom_range(2033, 2047));
    else             return {$urandom, $urandom};
  endfunction

  localparam int NV = 12;
  vec_t vecs [NV];
  obs_t o;

  initial begin
    vecs[0]  = '{1'b1, 64'h10,    1'b0, 1'b0, 64'h0,   64'h0,        0, 1'b1, 1'b1, 64'h1122334455667788};
    vecs[1]  = '{1'b0, 64'h0,     1'b1, 1'b1, 64'h100, 64'hDEADBEEF, 0, 1'b0, 1'b1, 64'h0};
    vecs[2]  = '{1'b0, 64'h0,     1'b1, 1'b0, 64'h100, 64'h0,        1, 1'b0, 1'b1, 64'hDEADBEEF};
    vecs[3]  = '{1'b1, 64'd2041,  1'b0, 1'b0, 64'h0,   64'h0,        0, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 64'h0,     1'b1, 1'b0, 64'd2040, 64'h0,       0, 1'b0, 1'b1, 64'hCAFEF00D00002040};
    vecs[5]  = '{1'b1, 64'h10,    1'b1, 1'b1, 64'h18,  64'h55,       0, 1'b1, 1'b1, 64'h1122334455667788};
    vecs[6]  = '{1'b0, 64'h0,     1'b1, 1'b1, 64'h18,  64'h55,       2, 1'b0, 1'b1, 64'h0};
    vecs[7]  = '{1'b1, 64'h18,    1'b0, 1'b0, 64'h0,   64'h0,        2, 1'b1, 1'b1, 64'h55};
    vecs[8]  = '{1'b1, 64'd2048,  1'b1, 1'b0, 64'h100, 64'h0,        1, 1'b0, 1'b1, 64'hDEADBEEF};
    vecs[9]  = '{1'b1, 64'd2048,  1'b0, 1'b0, 64'h0,   64'h0,        0, 1'b1, 1'b0, 64'h0};
    vecs[10] = '{1'b0, 64'h0,     1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h1234, 0, 1'b0, 1'b0, 64'h0};
    vecs[11] = '{1'b1, 64'h0,     1'b0, 1'b0, 64'h0,   64'h0,        3, 1'b1, 1'b1, 64'h0123456789ABCDEF};

    preload(64'h10, 64'h1122334455667788);
    preload(64'd2040, 64'hCAFEF00D00002040);
    preload(64'h0, 64'h0123456789ABCDEF);
    preload(64'h8, 64'h0808080808080808);

    // Reset state.
    tick();
    tick();
    check("reset ctl", 64'({f_gnt, f_valid, f_err, d_gnt, d_valid, d_err, m_en, m_we}), 64'h0);
    check("reset m_addr", m_addr, 64'h0);
    check("reset m_wdata", m_wdata, 64'h0);
    check("reset rdata", f_rdata | d_rdata, 64'h0);
    rst_n = 1'b1;

    // Vector table, starting from reset (last winner = D).
    for (int i = 0; i < NV; i++) begin
      f_req = vecs[i].f_req;  f_addr = vecs[i].f_addr;
      d_req = vecs[i].d_req;  d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      do_txn(vecs[i].delay, 0, o);
      check_txn($sformatf("vec%0d", i), o, vecs[i].exp_f, vecs[i].exp_ok,
                vecs[i].exp_f ? 1'b0 : vecs[i].d_we,
                vecs[i].exp_f ? vecs[i].f_addr : vecs[i].d_addr,
                vecs[i].d_wdata, vecs[i].delay, vecs[i].exp_rdata);
      if (vecs[i].exp_ok && !vecs[i].exp_f && vecs[i].d_we) ref_mem[vecs[i].d_addr] = vecs[i].d_wdata;
    end

    // Slow memory: D raised mid-access waits until F's response has gone out.
    f_req = 1'b1; f_addr = 64'h30;
    d_we = 1'b1; d_addr = 64'h38; d_wdata = 64'hA5A5_0000_5A5A_FFFF;
    do_txn(4, 3, o);
    check_txn("slow F", o, 1'b1, 1'b1, 1'b0, 64'h30, 64'h0, 4, ref_read(64'h30));
    do_txn(0, 0, o);
    check_txn("slow D", o, 1'b0, 1'b1, 1'b1, 64'h38, 64'hA5A5_0000_5A5A_FFFF, 0, 64'h0);
    ref_mem[64'h38] = 64'hA5A5_0000_5A5A_FFFF;

    // Tie arbitration after reset: F, D, F, D.
    apply_reset();
    f_addr = 64'h40; d_addr = 64'h80; d_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_req = 1'b1;
      d_req = 1'b1;
      do_txn(1, 0, o);
      check_txn($sformatf("tie%0d", i), o, (i % 2) == 0, 1'b1, 1'b0,
                (i % 2) == 0 ? 64'h40 : 64'h80, 64'h0, 1,
                ref_read((i % 2) == 0 ? 64'h40 : 64'h80));
    end
    f_req = 1'b0;
    d_req = 1'b0;

    // Reset in the middle of a BUSY access.
    f_req = 1'b1; f_addr = 64'h20;
    ack_delay = 10;
    tick();
    check("rst-mid gnt", 64'(f_gnt), 64'd1);
    f_req = 1'b0;
    tick();
    tick();
    check("rst-mid busy m_en", 64'(m_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst-mid ctl", 64'({f_gnt, f_valid, f_err, d_gnt, d_valid, d_err, m_en, m_we}), 64'h0);
    check("rst-mid m_addr", m_addr, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    auto_mem = 1'b0;
    m_ack = 1'b1;
    m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("late ack %0d", i), 64'({f_valid, d_valid, f_gnt, d_gnt, m_en}), 64'h0);
      m_ack = 1'b0;
    end
    auto_mem = 1'b1;
    f_req = 1'b1; f_addr = 64'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h48;
    do_txn(0, 0, o);
    check_txn("post-rst F", o, 1'b1, 1'b1, 1'b0, 64'h8, 64'h0, 0, 64'h0808080808080808);
    do_txn(0, 0, o);
    check_txn("post-rst D", o, 1'b0, 1'b1, 1'b0, 64'h48, 64'h0, 0, ref_read(64'h48));

    // Randomized transactions against the transaction-level model.
    apply_reset();
    begin
      bit          last_f;
      bit          exp_f, ok, we;
      logic [63:0] a, wd, exp_rd;
      int          dly;
      last_f = 1'b0;
      for (int i = 0; i < 150; i++) begin
        if (!f_req && $urandom_range(0, 2) != 0) begin
          f_req = 1'b1; f_addr = rand_addr();
        end
        if (!d_req && $urandom_range(0, 2) != 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = rand_addr(); d_wdata = {$urandom, $urandom};
        end
        if (!f_req && !d_req) begin
          f_req = 1'b1; f_addr = rand_addr();
        end
        exp_f  = f_req && (!d_req || last_f == 1'b0);
        a      = exp_f ? f_addr : d_addr;
        we     = exp_f ? 1'b0 : d_we;
        wd     = d_wdata;
        ok     = (a <= 64'd2040);
        dly    = $urandom_range(0, 3);
        exp_rd = (ok && !we) ? ref_read(a) : 64'h0;
        do_txn(dly, 0, o);
        check_txn($sformatf("rnd%0d", i), o, exp_f, ok, we, a, wd, dly, exp_rd);
        if (ok && we) ref_mem[a] = wd;
        last_f = exp_f;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the sequential Y86-64 core. It shares one 64-bit unified memory port between the fetch stage (read-only requester F) and the memory stage (read/write requester D). It runs a grant/valid handshake with each requester and a hold-until-ack handshake with the memory. Out-of-range addresses are flagged without touching memory.

## Interface
- MEM_SIZE, 2048, memory size in bytes; each access covers 8 bytes.
- AW, 64, address width.
- DW, 64, data width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  AW  fetch byte address.
- f_gnt  out  1  one-cycle pulse: F request accepted.
- f_valid  out  1  one-cycle pulse: F response ready.
- f_err  out  1  with f_valid: address out of range.
- f_rdata  out  DW  F read data, valid with f_valid.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  one-cycle pulse: D request accepted.
- d_valid  out  1  one-cycle pulse: D response ready.
- d_err  out  1  with d_valid: address out of range.
- d_rdata  out  DW  D read data; 0 for writes and errors.
- m_en  out  1  memory access active; held until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid when m_ack=1.
- m_ack  in  1  memory completion; sampled only in BUSY.

## Operation
- States: IDLE, BUSY, ERR. Registers: owner (F/D), last winner `last` (reset = D).
- IDLE, only f_req: grant F. Only d_req: grant D. Both: grant the requester that is not `last`, so ties alternate and F wins the first tie after reset.
- On grant: latch owner, address, we (F always reads) and wdata; set `last` = owner.
- Range check on the latched address: valid iff addr <= MEM_SIZE-8. No alignment check.
- Valid address: go to BUSY and drive m_en=1 with m_addr/m_we/m_wdata held stable until m_ack is sampled.
- Invalid address: go to ERR. No m_en.
- BUSY and m_ack=1: capture m_rdata into owner's rdata (forced to 0 for writes). Pulse owner's valid. Go to IDLE.
- ERR: pulse owner's valid and err with rdata=0. Go to IDLE.
- Requests are ignored in BUSY/ERR; the other requester holds req until it receives its gnt.
- Requester rule: deassert req by the edge after its gnt cycle; req still high in IDLE is a new request.
- m_ack in IDLE or ERR is ignored.
- Non-owner gnt/valid/err are always 0.
- Reset: state=IDLE, `last`=D, all outputs 0 (m_en, gnts, valids, errs, rdata, m_addr, m_wdata, m_we). Takes effect immediately, mid-transaction included.
- After reset the aborted transaction is dropped: no valid, and a late m_ack is ignored.

## Timing
- All outputs are registered.
- Edge 0: req sampled in IDLE.
- Cycle 1: gnt=1; m_en=1 (or ERR entered).
- m_ack high during cycle k (k ≥ 1) is sampled at edge k+1. Cycle k+1: valid=1, rdata/err valid, state IDLE.
- Earliest next acceptance is edge k+2, so back-to-back accesses take 3 cycles with a zero-wait memory.
- ERR path: valid/err in cycle 2, same as k=1.
- gnt and valid are never high together.

## Test plan
- F read: f_addr=0x10, m_ack in cycle 1 with m_rdata=0x1122334455667788. Expect f_gnt cycle 1, m_en=1, m_we=0, m_addr=0x10; f_valid cycle 2 with f_rdata=0x1122334455667788; d_* all 0.
- Tie arbitration after reset: f_req and d_req held high, m_ack=1 whenever m_en. Expect grants F, D, F, D in successive transactions; while one is BUSY, the other's gnt stays 0.
- D write: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF. Expect m_we=1, m_addr=0x100, m_wdata=0xDEADBEEF; d_valid with d_rdata=0, d_err=0.
- Range: f_addr=2041 → f_gnt, m_en stays 0, f_valid=f_err=1 in cycle 2. d_addr=2040 → normal memory access.
- Slow memory: m_ack asserted 4 cycles after m_en. m_en/m_addr stay stable for all 4 cycles; d_req raised mid-access gets d_gnt only after f_valid, on the edge after IDLE.
- Reset mid-access: rst_n low while BUSY with m_en=1 → all outputs 0 immediately. m_ack pulsed after release → no valid. Next f_req(0x8) completes normally and F wins a tie.
